// File: rtl/pc_pkg.sv
// Shared definitions for the IF-stage program-counter unit.
package pc_pkg;

    localparam int unsigned DEF_WORD = 32;
    localparam logic [DEF_WORD-1:0] DEF_RESET_VEC = 32'h0000_0000;
    localparam logic [DEF_WORD-1:0] DEF_EXC_VEC   = 32'h8000_0180;

    typedef enum logic [2:0] {
        SEL_SEQ = 3'd0,
        SEL_BR  = 3'd1,
        SEL_J   = 3'd2,
        SEL_JR  = 3'd3,
        SEL_EXC = 3'd4
    } pc_sel_e;

endpackage

// File: rtl/ras_stack.sv
// Circular return-address stack; pushing when full overwrites the oldest entry.
module ras_stack #(
    parameter int unsigned WORD      = 32,
    parameter int unsigned RAS_DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            push,
    input  logic            pop,
    input  logic [WORD-1:0] wdata,
    output logic [WORD-1:0] top,
    output logic            empty,
    output logic            full
);

    localparam int unsigned PW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam int unsigned CW = $clog2(RAS_DEPTH + 1);

    logic [WORD-1:0] mem [RAS_DEPTH];
    logic [PW-1:0]   ptr, ptr_nxt, wr_idx;
    logic [CW-1:0]   cnt, cnt_nxt;
    logic            wr_en;

    assign empty = (cnt == '0);
    assign full  = (cnt == CW'(RAS_DEPTH));
    assign top   = empty ? '0 : mem[ptr];

    // Push+pop on a non-empty stack replaces the top in place.
    always_comb begin
        ptr_nxt = ptr;
        cnt_nxt = cnt;
        wr_en   = 1'b0;
        wr_idx  = ptr;
        if (push && pop && !empty) begin
            wr_en = 1'b1;
        end else if (push) begin
            ptr_nxt = ptr + PW'(1);
            wr_idx  = ptr + PW'(1);
            wr_en   = 1'b1;
            if (!full) begin
                cnt_nxt = cnt + CW'(1);
            end
        end else if (pop && !empty) begin
            ptr_nxt = ptr - PW'(1);
            cnt_nxt = cnt - CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= '0;
            cnt <= '0;
        end else begin
            ptr <= ptr_nxt;
            cnt <= cnt_nxt;
        end
    end

    // Entries beyond count are don't-care, so storage carries no reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_idx] <= wdata;
        end
    end

endmodule

// File: rtl/pc_unit.sv
// IF-stage program counter: prioritised next-PC select, EPC capture and RAS.
module pc_unit
    import pc_pkg::*;
#(
    parameter int unsigned     WORD      = 32,
    parameter logic [WORD-1:0] RESET_VEC = DEF_RESET_VEC,
    parameter logic [WORD-1:0] EXC_VEC   = DEF_EXC_VEC,
    parameter int unsigned     INC       = 4,
    parameter int unsigned     RAS_DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            pc_write,
    input  logic            branch_taken,
    input  logic [WORD-1:0] branch_target,
    input  logic            jump,
    input  logic [WORD-1:0] jump_target,
    input  logic            jr,
    input  logic [WORD-1:0] jr_target,
    input  logic            exception,
    input  logic [WORD-1:0] exc_pc,
    input  logic            ras_push,
    input  logic [WORD-1:0] ret_addr,
    input  logic            ras_pop,
    output logic [WORD-1:0] curr,
    output logic [WORD-1:0] epc,
    output logic [WORD-1:0] ras_top,
    output logic            ras_empty,
    output logic            ras_full
);

    pc_sel_e         sel;
    logic [WORD-1:0] next_pc;
    logic            ras_push_g;
    logic            ras_pop_g;

    always_comb begin
        sel = SEL_SEQ;
        if (exception) begin
            sel = SEL_EXC;
        end else if (jr) begin
            sel = SEL_JR;
        end else if (jump) begin
            sel = SEL_J;
        end else if (branch_taken) begin
            sel = SEL_BR;
        end
    end

    always_comb begin
        next_pc = curr + WORD'(INC);
        case (sel)
            SEL_EXC: next_pc = EXC_VEC;
            SEL_JR:  next_pc = jr_target;
            SEL_J:   next_pc = jump_target;
            SEL_BR:  next_pc = branch_target;
            default: next_pc = curr + WORD'(INC);
        endcase
    end

    // Exceptions redirect even through a stall.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            curr <= RESET_VEC;
            epc  <= '0;
        end else if (exception) begin
            curr <= next_pc;
            epc  <= exc_pc;
        end else if (pc_write) begin
            curr <= next_pc;
        end
    end

    assign ras_push_g = ras_push && pc_write && !exception;
    assign ras_pop_g  = ras_pop  && pc_write && !exception;

    ras_stack #(
        .WORD      (WORD),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk   (clk),
        .rst   (rst),
        .push  (ras_push_g),
        .pop   (ras_pop_g),
        .wdata (ret_addr),
        .top   (ras_top),
        .empty (ras_empty),
        .full  (ras_full)
    );

endmodule

// File: tb/tb_pc_unit.sv
// Directed scoreboard bench for pc_unit with default parameters.
module tb_pc_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        pc_write;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        jump;
    logic [31:0] jump_target;
    logic        jr;
    logic [31:0] jr_target;
    logic        exception;
    logic [31:0] exc_pc;
    logic        ras_push;
    logic [31:0] ret_addr;
    logic        ras_pop;
    logic [31:0] curr;
    logic [31:0] epc;
    logic [31:0] ras_top;
    logic        ras_empty;
    logic        ras_full;

    typedef struct {
        string       tag;
        logic [31:0] curr;
        logic [31:0] epc;
        logic [31:0] top;
        logic        empty;
        logic        full;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    pc_unit dut (
        .clk           (clk),
        .rst           (rst),
        .pc_write      (pc_write),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .jump          (jump),
        .jump_target   (jump_target),
        .jr            (jr),
        .jr_target     (jr_target),
        .exception     (exception),
        .exc_pc        (exc_pc),
        .ras_push      (ras_push),
        .ret_addr      (ret_addr),
        .ras_pop       (ras_pop),
        .curr          (curr),
        .epc           (epc),
        .ras_top       (ras_top),
        .ras_empty     (ras_empty),
        .ras_full      (ras_full)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input string field, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s.%s observed=%h expected=%h", tag, field, obs, exp);
        end
    endtask

    task automatic expect_push(input string tag, input logic [31:0] c, input logic [31:0] e,
                               input logic [31:0] t, input logic em, input logic fu);
        exp_t x;
        x.tag = tag; x.curr = c; x.epc = e; x.top = t; x.empty = em; x.full = fu;
        sb.push_back(x);
    endtask

    task automatic compare_pop();
        exp_t x;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL scoreboard observed=empty expected=entry");
            return;
        end
        x = sb.pop_front();
        chk(x.tag, "curr",  curr, x.curr);
        chk(x.tag, "epc",   epc,  x.epc);
        chk(x.tag, "top",   ras_top, x.top);
        chk(x.tag, "empty", {31'd0, ras_empty}, {31'd0, x.empty});
        chk(x.tag, "full",  {31'd0, ras_full},  {31'd0, x.full});
    endtask

    task automatic idle();
        pc_write = 1'b1; branch_taken = 1'b0; jump = 1'b0; jr = 1'b0;
        exception = 1'b0; ras_push = 1'b0; ras_pop = 1'b0;
    endtask

    // Drives are already set; queue expectation, clock once, compare after the edge.
    task automatic step(input string tag, input logic [31:0] c, input logic [31:0] e,
                        input logic [31:0] t, input logic em, input logic fu);
        expect_push(tag, c, e, t, em, fu);
        @(posedge clk);
        #1;
        compare_pop();
        idle();
    endtask

    initial begin
        rst = 1'b1;
        idle();
        pc_write = 1'b0;
        branch_target = '0; jump_target = '0; jr_target = '0; exc_pc = '0; ret_addr = '0;
        #12;
        expect_push("reset", 32'h0, 32'h0, 32'h0, 1'b1, 1'b0);
        compare_pop();
        rst = 1'b0;
        idle();

        step("seq1", 32'h4, 32'h0, 32'h0, 1'b1, 1'b0);
        step("seq2", 32'h8, 32'h0, 32'h0, 1'b1, 1'b0);
        step("seq3", 32'hC, 32'h0, 32'h0, 1'b1, 1'b0);

        pc_write = 1'b0; branch_taken = 1'b1; branch_target = 32'h100;
        step("stall", 32'hC, 32'h0, 32'h0, 1'b1, 1'b0);

        pc_write = 1'b0; exception = 1'b1; exc_pc = 32'h40;
        step("exc_stall", 32'h8000_0180, 32'h40, 32'h0, 1'b1, 1'b0);

        jr = 1'b1; jr_target = 32'h200; jump = 1'b1; jump_target = 32'h300;
        branch_taken = 1'b1; branch_target = 32'h400;
        step("priority", 32'h200, 32'h40, 32'h0, 1'b1, 1'b0);

        ras_push = 1'b1; ret_addr = 32'h10; step("push10", 32'h204, 32'h40, 32'h10, 1'b0, 1'b0);
        ras_push = 1'b1; ret_addr = 32'h20; step("push20", 32'h208, 32'h40, 32'h20, 1'b0, 1'b0);
        ras_push = 1'b1; ret_addr = 32'h30; step("push30", 32'h20C, 32'h40, 32'h30, 1'b0, 1'b0);
        ras_push = 1'b1; ret_addr = 32'h40; step("push40", 32'h210, 32'h40, 32'h40, 1'b0, 1'b1);
        ras_push = 1'b1; ret_addr = 32'h50; step("push50", 32'h214, 32'h40, 32'h50, 1'b0, 1'b1);

        ras_pop = 1'b1; step("pop1", 32'h218, 32'h40, 32'h40, 1'b0, 1'b0);
        ras_pop = 1'b1; step("pop2", 32'h21C, 32'h40, 32'h30, 1'b0, 1'b0);
        ras_pop = 1'b1; step("pop3", 32'h220, 32'h40, 32'h20, 1'b0, 1'b0);
        ras_pop = 1'b1; step("pop4", 32'h224, 32'h40, 32'h0,  1'b1, 1'b0);
        ras_pop = 1'b1; step("pop5", 32'h228, 32'h40, 32'h0,  1'b1, 1'b0);

        ras_push = 1'b1; ret_addr = 32'h10; step("repush10", 32'h22C, 32'h40, 32'h10, 1'b0, 1'b0);
        ras_push = 1'b1; ret_addr = 32'h20; step("repush20", 32'h230, 32'h40, 32'h20, 1'b0, 1'b0);
        ras_push = 1'b1; ras_pop = 1'b1; ret_addr = 32'h99;
        step("pushpop", 32'h234, 32'h40, 32'h99, 1'b0, 1'b0);
        ras_pop = 1'b1; step("pop_after_pp", 32'h238, 32'h40, 32'h10, 1'b0, 1'b0);

        ras_push = 1'b1; ret_addr = 32'h77; exception = 1'b1; exc_pc = 32'h1234;
        step("push_exc", 32'h8000_0180, 32'h1234, 32'h10, 1'b0, 1'b0);
        pc_write = 1'b0; ras_push = 1'b1; ret_addr = 32'h55;
        step("push_stall", 32'h8000_0180, 32'h1234, 32'h10, 1'b0, 1'b0);

        jump = 1'b1; jump_target = 32'hFFFF_FFFC;
        step("jump_top", 32'hFFFF_FFFC, 32'h1234, 32'h10, 1'b0, 1'b0);
        step("wrap", 32'h0, 32'h1234, 32'h10, 1'b0, 1'b0);
        step("post_wrap", 32'h4, 32'h1234, 32'h10, 1'b0, 1'b0);

        #2;
        rst = 1'b1;
        #1;
        expect_push("async_rst", 32'h0, 32'h0, 32'h0, 1'b1, 1'b0);
        compare_pop();
        rst = 1'b0;
        step("after_rst", 32'h4, 32'h0, 32'h0, 1'b1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #20000;
        $fatal(1, "FAIL timeout observed=running expected=finished");
    end

endmodule
